// File: rtl/mipi_apb_share_arb.sv
// mipi_apb_share_arb: round-robin share of the MIPI APB port between the MCU bridge (m0) and the init sequencer (m1); optional ACCESS timeout under ARB_TIMEOUT_EN
module mipi_apb_share_arb #(
    parameter int              AW       = 20,
    parameter int              DW       = 32,
    parameter int              TO_CYC   = 255,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
    input  logic          cpuclk,
    input  logic          rstn,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic [AW-1:0] paddr,
    output logic          pwrite,
    output logic [DW-1:0] pwdata,
    output logic          psel,
    output logic          penable,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    output logic          busy,
    output logic          gnt_id,
    output logic          to_err,
    input  logic          err_clr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t state, state_nxt;
    logic   last_gnt;
    logic   any_req;
    logic   sel;
    logic   timeout;
    logic   finish;

    // On a tie the requester that did not own the previous transfer wins
    assign any_req = m0_req | m1_req;
    assign sel     = (m0_req & m1_req) ? ~last_gnt : m1_req;
    assign finish  = (state == ACCESS) && (pready || timeout);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign timeout = (state == ACCESS) && !pready && (to_cnt == 8'(TO_CYC - 1));

    // ACCESS-phase cycle counter, restarted whenever we leave ACCESS
    always_ff @(posedge cpuclk or negedge rstn) begin
        if (!rstn)
            to_cnt <= '0;
        else
            to_cnt <= (state == ACCESS) ? to_cnt + 8'd1 : 8'd0;
    end

    // Sticky timeout flag; a clear wins over a coincident set
    always_ff @(posedge cpuclk or negedge rstn) begin
        if (!rstn)
            to_err <= 1'b0;
        else
            to_err <= err_clr ? 1'b0 : (timeout ? 1'b1 : to_err);
    end
`else
    assign timeout = 1'b0;
    assign to_err  = 1'b0 & err_clr;
`endif

    // State register
    always_ff @(posedge cpuclk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and phase decode; APB strobes come straight from state so reset drops them at once
    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    state_nxt = any_req ? SETUP : IDLE;
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel      = 1'b1;
                penable   = 1'b1;
                state_nxt = finish ? DONE : ACCESS;
            end
            DONE: begin
                m0_ack    = ~gnt_id;
                m1_ack    = gnt_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping and APB request latch; the bus fields hold between transfers
    always_ff @(posedge cpuclk or negedge rstn) begin
        if (!rstn) begin
            gnt_id   <= 1'b0;
            last_gnt <= 1'b1;
            paddr    <= '0;
            pwdata   <= '0;
            pwrite   <= 1'b0;
        end else if (state == IDLE && any_req) begin
            gnt_id   <= sel;
            last_gnt <= sel;
            paddr    <= sel ? m1_addr  : m0_addr;
            pwdata   <= sel ? m1_wdata : m0_wdata;
            pwrite   <= sel ? m1_wr    : m0_wr;
        end
    end

    // Read data return to the owner only; writes leave both rdata registers alone
    always_ff @(posedge cpuclk or negedge rstn) begin
        if (!rstn) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (finish && !pwrite) begin
            if (gnt_id)
                m1_rdata <= timeout ? ERR_DATA : prdata;
            else
                m0_rdata <= timeout ? ERR_DATA : prdata;
        end
    end

endmodule

// File: tb/tb_mipi_apb_share_arb.sv
// tb_mipi_apb_share_arb: directed scoreboard bench for the shared MIPI APB arbiter
module tb_mipi_apb_share_arb;

    logic        cpuclk = 1'b0;
    logic        rstn   = 1'b0;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [19:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [19:0] paddr;
    logic        pwrite, psel, penable, busy, gnt_id, to_err;
    logic [31:0] pwdata;
    logic [31:0] prd_v = '0;
    logic        pready;
    logic        err_clr = 1'b0;

    int cyc = 0;
    int acc_cnt = 0;
    int nwait = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        id;
        int          cyc;
        logic        wr;
        logic [19:0] addr;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];

    mipi_apb_share_arb dut (
        .cpuclk(cpuclk), .rstn(rstn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
        .prdata(prd_v), .pready(pready),
        .busy(busy), .gnt_id(gnt_id), .to_err(to_err), .err_clr(err_clr)
    );

    always #5 cpuclk = ~cpuclk;

    always @(posedge cpuclk) cyc <= cyc + 1;

    // Slave model: pready rises after nwait ACCESS cycles
    always @(posedge cpuclk) acc_cnt <= penable ? acc_cnt + 1 : 0;
    assign pready = penable && (acc_cnt >= nwait);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pops one expected completion
    always @(negedge cpuclk) begin
        if (m0_ack || m1_ack) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_route", {30'd0, m1_ack, m0_ack}, e.id ? 32'd2 : 32'd1);
                chk("ack_cycle", cyc, e.cyc);
                chk("gnt_id", {31'd0, gnt_id}, {31'd0, e.id});
                chk("paddr", {12'd0, paddr}, {12'd0, e.addr});
                chk("pwrite", {31'd0, pwrite}, {31'd0, e.wr});
                chk(e.id ? "m1_rdata" : "m0_rdata", e.id ? m1_rdata : m0_rdata, e.rd);
            end
        end
    end

    task automatic start(input logic id, input logic wr, input logic [19:0] a,
                         input logic [31:0] d, input int nw, input logic [31:0] prd);
        nwait = nw;
        prd_v = prd;
        if (id) begin
            m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic expect_ack(input logic id, input int c, input logic wr,
                              input logic [19:0] a, input logic [31:0] rd);
        exp_t e;
        e.id = id; e.cyc = c; e.wr = wr; e.addr = a; e.rd = rd;
        q.push_back(e);
    endtask

    task automatic wait_ack(input logic id, input bit drop);
        bit seen = 1'b0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge cpuclk);
            seen = id ? m1_ack : m0_ack;
        end
        if (!seen) chk(id ? "m1_ack_wait" : "m0_ack_wait", 32'd0, 32'd1);
        @(posedge cpuclk);
        #1;
        if (drop) begin
            if (id) m1_req = 1'b0; else m0_req = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge cpuclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        idle(2);
        chk("rst_strobes", {28'd0, psel, penable, busy, pwrite}, 32'd0);
        chk("rst_acks", {28'd0, m0_ack, m1_ack, gnt_id, to_err}, 32'd0);
        chk("rst_paddr", {12'd0, paddr}, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        rstn = 1'b1;
        idle(2);

        // 1: m0 write, zero wait
        c0 = cyc;
        start(0, 1, 20'h00010, 32'h12345678, 0, 32'h0);
        expect_ack(0, c0 + 3, 1, 20'h00010, 32'h0);
        @(negedge cpuclk);
        chk("t1_psel_c0", {31'd0, psel}, 32'd0);
        @(negedge cpuclk);
        chk("t1_setup", {30'd0, psel, penable}, 32'd2);
        chk("t1_pwdata", pwdata, 32'h12345678);
        @(negedge cpuclk);
        chk("t1_access", {30'd0, psel, penable}, 32'd3);
        wait_ack(0, 1);
        idle(2);

        // 2: m1 read, three wait states
        c0 = cyc;
        start(1, 0, 20'h00020, 32'h0, 3, 32'hA5A5A5A5);
        expect_ack(1, c0 + 6, 0, 20'h00020, 32'hA5A5A5A5);
        wait_ack(1, 1);
        idle(2);

        // 3: both held for four transfers, alternating from m0
        c0 = cyc;
        start(0, 0, 20'h00100, 32'h0, 0, 32'h0BADC0DE);
        start(1, 1, 20'h00200, 32'hCAFEF00D, 0, 32'h0BADC0DE);
        expect_ack(0, c0 + 3, 0, 20'h00100, 32'h0BADC0DE);
        expect_ack(1, c0 + 7, 1, 20'h00200, 32'hA5A5A5A5);
        expect_ack(0, c0 + 11, 0, 20'h00100, 32'h0BADC0DE);
        expect_ack(1, c0 + 15, 1, 20'h00200, 32'hA5A5A5A5);
        wait_ack(0, 0);
        wait_ack(1, 0);
        wait_ack(0, 1);
        wait_ack(1, 1);
        idle(2);

        // 4: reset in ACCESS of an m0 transfer, then a tie must go to m0
        start(0, 0, 20'h00300, 32'h0, 100, 32'h77777777);
        @(negedge cpuclk);
        @(negedge cpuclk);
        @(negedge cpuclk);
        chk("t4_in_access", {30'd0, psel, penable}, 32'd3);
        #2;
        rstn = 1'b0;
        #1;
        chk("t4_async_drop", {29'd0, psel, penable, busy}, 32'd0);
        m0_req = 1'b0;
        idle(3);
        chk("t4_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        rstn = 1'b1;
        idle(1);
        c0 = cyc;
        start(0, 0, 20'h00400, 32'h0, 0, 32'h13579BDF);
        start(1, 0, 20'h00500, 32'h0, 0, 32'h13579BDF);
        expect_ack(0, c0 + 3, 0, 20'h00400, 32'h13579BDF);
        expect_ack(1, c0 + 7, 0, 20'h00500, 32'h13579BDF);
        wait_ack(0, 1);
        wait_ack(1, 1);
        idle(2);

`ifdef ARB_TIMEOUT_EN
        // 5: stuck pready forces completion with error data
        c0 = cyc;
        start(0, 0, 20'h00700, 32'h0, 100000, 32'h11111111);
        expect_ack(0, c0 + 257, 0, 20'h00700, 32'hDEADBEEF);
        wait_ack(0, 1);
        chk("t5_to_err_set", {31'd0, to_err}, 32'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t5_to_err_clr", {31'd0, to_err}, 32'd0);
`else
        // 6: long wait without timeout completes normally
        c0 = cyc;
        start(1, 0, 20'h00600, 32'h0, 1000, 32'h600D600D);
        expect_ack(1, c0 + 1003, 0, 20'h00600, 32'h600D600D);
        wait_ack(1, 1);
        chk("t6_to_err", {31'd0, to_err}, 32'd0);
`endif
        idle(3);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
